// File: rtl/tile_event_unit.sv
// Tile event/wake-up controller: latches accelerator events, wakes the WFE-sleeping core, raises a level irq.
// Optional: define TILE_EVT_BUSY_WAKE_EN to also treat a busy_i 1->0 edge as an end-of-job event on line N_EVT-1.
module tile_event_unit #(
   parameter int unsigned N_EVT             = 2,
   parameter int unsigned WAKE_PULSE_CYCLES = 1,
   parameter int unsigned CNT_W             = 16
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [N_EVT-1:0] evt_i,
   input  logic             busy_i,
   input  logic [N_EVT-1:0] evt_mask_i,
   input  logic [N_EVT-1:0] irq_mask_i,
   input  logic             core_sleep_i,
   output logic             wu_wfe_o,
   output logic             irq_o,
   output logic [N_EVT-1:0] pending_o,
   input  logic             clr_valid_i,
   input  logic [N_EVT-1:0] clr_mask_i,
   output logic             clr_ready_o,
   output logic [CNT_W-1:0] evt_cnt_o
);

   localparam int unsigned PW = $clog2(WAKE_PULSE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_SLEEP,
      ST_WAKE
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    pulse_q, pulse_d;
   logic [N_EVT-1:0] pending_q, pending_d;
   logic [N_EVT-1:0] evt_set;
   logic [N_EVT-1:0] clr_bits;
   logic [CNT_W-1:0] cnt_q;
   logic             irq_q;
   logic             wu_q;
   logic             ready_q;
   logic             wake;
   logic             clr_hs;

`ifdef TILE_EVT_BUSY_WAKE_EN
   logic busy_q;
   logic busy_fall;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) busy_q <= 1'b0;
      else         busy_q <= busy_i;
   end

   assign busy_fall = busy_q & ~busy_i;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      evt_set            = evt_i;
      evt_set[N_EVT-1]   = evt_i[N_EVT-1] | busy_fall;
   end
`else
   logic unused_busy;
   assign unused_busy = busy_i;
   assign evt_set     = evt_i;
`endif

   // Clear only on a real handshake; a same-cycle event on the bit still wins.
   assign clr_hs    = clr_valid_i & ready_q;
   assign clr_bits  = clr_hs ? clr_mask_i : '0;
   assign pending_d = (pending_q & ~clr_bits) | evt_set;
   assign wake      = |(pending_q & evt_mask_i);

   always_comb begin
      state_d = state_q;
      pulse_d = pulse_q;
      case (state_q)
         ST_RUN: begin
            if (core_sleep_i) state_d = ST_SLEEP;
         end
         ST_SLEEP: begin
            if (wake) begin
               state_d = ST_WAKE;
               pulse_d = PW'(WAKE_PULSE_CYCLES);
            end else if (!core_sleep_i) begin
               state_d = ST_RUN;
            end
         end
         ST_WAKE: begin
            if (pulse_q > PW'(1)) begin
               pulse_d = pulse_q - 1'b1;
            end else begin
               pulse_d = '0;
               state_d = core_sleep_i ? ST_SLEEP : ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            pulse_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_RUN;
         pulse_q   <= '0;
         pending_q <= '0;
         cnt_q     <= '0;
         irq_q     <= 1'b0;
         wu_q      <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         pending_q <= pending_d;
         irq_q     <= |(pending_q & irq_mask_i);
         wu_q      <= (state_d == ST_WAKE) && (pulse_d != '0);
         ready_q   <= (state_d != ST_WAKE);
         if (|evt_set && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign wu_wfe_o    = wu_q;
   assign irq_o       = irq_q;
   assign pending_o   = pending_q;
   assign clr_ready_o = ready_q;
   assign evt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_tile_event_unit.sv
// Directed bench for tile_event_unit: a vector table for pending/irq/counter/clear, then hand sequences
// for sleep/wake pulses, lost-wake, clear during WAKE, saturation, busy end-of-job and reset mid-wake.
module tb_tile_event_unit;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] evt, evt_mask, irq_mask, clr_mask;
   logic       busy, core_sleep, clr_valid;

   logic       wu, irq, ready;
   logic [1:0] pend;
   logic [3:0] cnt;
   logic       wu1, irq1, ready1;
   logic [1:0] pend1;
   logic [3:0] cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tile_event_unit #(.N_EVT(2), .WAKE_PULSE_CYCLES(3), .CNT_W(4)) dut (
      .clk_i(clk), .rstn_i(rstn), .evt_i(evt), .busy_i(busy),
      .evt_mask_i(evt_mask), .irq_mask_i(irq_mask), .core_sleep_i(core_sleep),
      .wu_wfe_o(wu), .irq_o(irq), .pending_o(pend),
      .clr_valid_i(clr_valid), .clr_mask_i(clr_mask), .clr_ready_o(ready),
      .evt_cnt_o(cnt)
   );

   tile_event_unit #(.N_EVT(2), .WAKE_PULSE_CYCLES(1), .CNT_W(4)) dut1 (
      .clk_i(clk), .rstn_i(rstn), .evt_i(evt), .busy_i(busy),
      .evt_mask_i(evt_mask), .irq_mask_i(irq_mask), .core_sleep_i(core_sleep),
      .wu_wfe_o(wu1), .irq_o(irq1), .pending_o(pend1),
      .clr_valid_i(clr_valid), .clr_mask_i(clr_mask), .clr_ready_o(ready1),
      .evt_cnt_o(cnt1)
   );

   typedef struct {
      logic [1:0] evt;
      logic [1:0] irq_mask;
      logic       clr_valid;
      logic [1:0] clr_mask;
      logic [1:0] exp_pend;
      logic       exp_irq;
      logic [3:0] exp_cnt;
   } vec_t;

   vec_t vecs[16];

`ifdef TILE_EVT_BUSY_WAKE_EN
   localparam logic [1:0] BUSY_PEND = 2'b10;
   localparam logic       BUSY_WU   = 1'b1;
   localparam logic [3:0] BUSY_CNT  = 4'd1;
`else
   localparam logic [1:0] BUSY_PEND = 2'b00;
   localparam logic       BUSY_WU   = 1'b0;
   localparam logic [3:0] BUSY_CNT  = 4'd0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] tr, tr1, trr;
   logic [5:0] ta, ta1;

   initial begin
      vecs[0]  = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0};
      vecs[1]  = '{2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 4'd1};
      vecs[2]  = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 4'd1};
      vecs[3]  = '{2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 4'd1};
      vecs[4]  = '{2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1, 4'd2};
      vecs[5]  = '{2'b00, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 4'd2};
      vecs[6]  = '{2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 4'd2};
      vecs[7]  = '{2'b11, 2'b10, 1'b0, 2'b00, 2'b11, 1'b0, 4'd3};
      vecs[8]  = '{2'b10, 2'b10, 1'b0, 2'b00, 2'b11, 1'b1, 4'd4};
      vecs[9]  = '{2'b00, 2'b10, 1'b1, 2'b11, 2'b00, 1'b1, 4'd4};
      vecs[10] = '{2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 4'd4};
      vecs[11] = '{2'b10, 2'b10, 1'b1, 2'b01, 2'b10, 1'b0, 4'd5};
      vecs[12] = '{2'b01, 2'b10, 1'b1, 2'b10, 2'b01, 1'b1, 4'd6};
      vecs[13] = '{2'b00, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 4'd6};
      vecs[14] = '{2'b00, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 4'd6};
      vecs[15] = '{2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'd6};

      rstn = 1'b0; evt = '0; evt_mask = '0; irq_mask = '0; clr_mask = '0;
      busy = 1'b0; core_sleep = 1'b0; clr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset pend", pend, 0);
      check("reset irq", irq, 0);
      check("reset cnt", cnt, 0);
      check("reset wu", wu, 0);
      check("reset ready", ready, 0);
      #3 rstn = 1'b1;

      // Vector table: RUN state, no sleep.
      for (int i = 0; i < 16; i++) begin
         evt = vecs[i].evt; irq_mask = vecs[i].irq_mask;
         clr_valid = vecs[i].clr_valid; clr_mask = vecs[i].clr_mask;
         step();
         check($sformatf("vec%0d pend", i), pend, vecs[i].exp_pend);
         check($sformatf("vec%0d irq", i), irq, vecs[i].exp_irq);
         check($sformatf("vec%0d cnt", i), cnt, vecs[i].exp_cnt);
         check($sformatf("vec%0d wu", i), wu, 0);
         check($sformatf("vec%0d ready", i), ready, 1);
      end
      evt = '0; irq_mask = '0; clr_valid = 1'b0; clr_mask = '0;

      // Sleep, event on line 1, pulse widths and re-pulse while the core keeps sleeping.
      evt_mask = 2'b10; core_sleep = 1'b1;
      step();
      check("sleep entry wu", wu, 0);
      evt = 2'b10;
      step();
      check("sleep evt pend", pend, 2'b10);
      check("sleep evt wu", wu, 0);
      evt = '0;
      for (int k = 0; k < 8; k++) begin
         step();
         tr[7-k] = wu; tr1[7-k] = wu1; trr[7-k] = ready;
      end
      check("wake trace p3", tr, 8'b1110_1110);
      check("wake trace p1", tr1, 8'b1010_1010);
      check("ready trace p3", trr, 8'b0001_0001);
      core_sleep = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         ta[5-k] = wu; ta1[5-k] = wu1;
      end
      check("exit trace p3", ta, 6'b111000);
      check("exit trace p1", ta1, 6'b100000);
      check("exit ready", ready, 1);
      clr_valid = 1'b1; clr_mask = 2'b11;
      step();
      check("clear after wake", pend, 2'b00);
      clr_valid = 1'b0; clr_mask = '0;

      // Pending before sleep: wake must follow entry without being lost.
      evt_mask = 2'b01; evt = 2'b01;
      step();
      evt = '0; core_sleep = 1'b1;
      step();
      check("nolost f1 wu", wu, 0);
      step();
      check("nolost f2 wu", wu, 1);
      check("nolost f2 wu p1", wu1, 1);
      check("nolost f2 ready", ready, 0);

      // Clear held through WAKE, accepted on the first ready cycle.
      clr_valid = 1'b1; clr_mask = 2'b01; core_sleep = 1'b0;
      step();
      check("wclr f3 ready", ready, 0);
      check("wclr f3 pend", pend, 2'b01);
      step();
      check("wclr f4 ready", ready, 0);
      check("wclr f4 pend", pend, 2'b01);
      step();
      check("wclr f5 ready", ready, 1);
      check("wclr f5 pend", pend, 2'b01);
      step();
      check("wclr f6 pend", pend, 2'b00);
      clr_valid = 1'b0; clr_mask = '0;
      check("cnt before sat", cnt, 4'd8);

      // Saturation: 21 event cycles from 8.
      evt_mask = '0; evt = 2'b01;
      for (int k = 1; k <= 21; k++) begin
         step();
         if (k == 6) check("sat k6", cnt, 4'd14);
         if (k == 7) check("sat k7", cnt, 4'hF);
         if (k == 8) check("sat k8", cnt, 4'hF);
      end
      check("sat end", cnt, 4'hF);
      evt = '0; clr_valid = 1'b1; clr_mask = 2'b11;
      step();
      clr_valid = 1'b0; clr_mask = '0;

      // Reset in the middle of a wake pulse.
      evt_mask = 2'b10; evt = 2'b10;
      step();
      evt = '0; core_sleep = 1'b1;
      for (int k = 0; k < 5 && !wu; k++) step();
      check("rst wake reached", wu, 1);
      #2 rstn = 1'b0;
      #1;
      check("rst mid pend", pend, 0);
      check("rst mid irq", irq, 0);
      check("rst mid cnt", cnt, 0);
      check("rst mid wu", wu, 0);
      check("rst mid wu p1", wu1, 0);
      check("rst mid ready", ready, 0);
      core_sleep = 1'b0;
      @(posedge clk);
      #3 rstn = 1'b1;
      step();
      check("post rst ready", ready, 1);
      check("post rst wu", wu, 0);

      // Busy falling edge while sleeping.
      busy = 1'b1; core_sleep = 1'b1; evt_mask = 2'b10;
      step();
      step();
      check("busy sleep wu", wu, 0);
      check("busy sleep pend", pend, 2'b00);
      busy = 1'b0;
      step();
      check("busy fall pend", pend, BUSY_PEND);
      check("busy fall cnt", cnt, BUSY_CNT);
      step();
      check("busy fall wu", wu, BUSY_WU);
      core_sleep = 1'b0; clr_valid = 1'b1; clr_mask = 2'b11;
      repeat (8) step();
      check("busy final pend", pend, 2'b00);
      check("busy final wu", wu, 0);
      clr_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tile_event_unit.md
Name: tile_event_unit

Overview:
- Tile-side event/wake-up controller: the consuming end of the accelerator `evt_o`/`busy_o` outputs and the driving end of the core `wu_wfe_i` input.
- Latches accelerator event pulses into pending bits and wakes the core from wait-for-event sleep when an enabled event is pending.
- Raises a level interrupt for irq-enabled pending events.
- Software clears pending bits through a valid/ready clear port.

Parameters:
- N_EVT, 2, number of accelerator event lines.
- WAKE_PULSE_CYCLES, 1, cycles `wu_wfe_o` stays high per wake-up (>=1).
- CNT_W, 16, width of the saturating event counter.

Ports:
- clk_i  input  1  clock.
- rstn_i  input  1  reset. Asynchronous, active-low.
- evt_i  input  N_EVT  accelerator event pulses, one bit per source.
- busy_i  input  1  accelerator busy.
- evt_mask_i  input  N_EVT  wake-up enable per source.
- irq_mask_i  input  N_EVT  interrupt enable per source.
- core_sleep_i  input  1  core is in WFE sleep.
- wu_wfe_o  output  1  wake-up request to the core.
- irq_o  output  1  level interrupt.
- pending_o  output  N_EVT  pending event bits.
- clr_valid_i  input  1  clear request valid.
- clr_mask_i  input  N_EVT  bits to clear.
- clr_ready_o  output  1  clear request accepted.
- evt_cnt_o  output  CNT_W  saturating count of event cycles.

Behaviour:
- Reset values (asynchronous assertion):
  - `pending_o`=0, `evt_cnt_o`=0, `wu_wfe_o`=0, `irq_o`=0, `clr_ready_o`=0.
  - FSM=RUN, pulse counter=0.
  - Reset mid-wake aborts the pulse immediately.
- Pending bits:
  - `pending[i]` is set on any cycle with `evt_i[i]`=1.
  - `pending[i]` is cleared on a clear handshake (`clr_valid_i & clr_ready_o`) with `clr_mask_i[i]`=1.
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Update visible on `pending_o` the cycle after the event.
- `irq_o` is registered: `irq_o` = |(`pending` & `irq_mask_i`), one cycle after the pending change.
- Counter:
  - `evt_cnt_o` increments by 1 on each cycle where |`evt_i`=1.
  - Saturates at all-ones; never wraps.
- Clear handshake:
  - `clr_ready_o`=1 in RUN and SLEEP, 0 in WAKE.
  - A request held while not ready is accepted on the first ready cycle.
  - `clr_ready_o` is registered from next state.
- FSM states:
  - RUN:
    - `core_sleep_i`=1 -> SLEEP.
  - SLEEP:
    - wake = |(`pending` & `evt_mask_i`), evaluated on the registered pending.
    - wake=1 -> WAKE, pulse counter loaded with WAKE_PULSE_CYCLES.
    - If wake was already true on entry, WAKE follows the next cycle, so no wake-up is lost.
    - `core_sleep_i`=0 with no wake (debug exit) -> RUN, no pulse.
  - WAKE:
    - `wu_wfe_o`=1 for exactly WAKE_PULSE_CYCLES cycles.
    - Then -> RUN once `core_sleep_i`=0.
    - If the core is still sleeping after the pulse, -> SLEEP, which re-pulses if wake still holds.
- `wu_wfe_o` is registered, high only in WAKE while the pulse counter is nonzero.
- Pending bits are not auto-cleared by wake-up; software clears them.
- Masks are sampled combinationally every cycle; a mask change while in SLEEP can trigger wake.

Optional Feature:
- Macro: TILE_EVT_BUSY_WAKE_EN.
- Defined:
  - A registered copy of `busy_i` detects the 1->0 edge.
  - The falling edge sets `pending[N_EVT-1]` as end-of-job, ORed with `evt_i[N_EVT-1]`.
  - The edge also counts in `evt_cnt_o`.
- Undefined:
  - `busy_i` is unused; no busy register exists.

Test Plan:
- Reset, then `evt_i`=2'b01 for 1 cycle -> `pending_o`=2'b01 next cycle, `evt_cnt_o`=1, `irq_o`=0 with `irq_mask_i`=0.
- `evt_mask_i`=2'b10, `core_sleep_i`=1, then `evt_i`=2'b10 -> SLEEP, then WAKE.
  - `wu_wfe_o` high for exactly WAKE_PULSE_CYCLES (test 1 and 3).
  - Drop `core_sleep_i` -> RUN.
- `pending`=2'b01 and `evt_mask_i`=2'b01 before sleep, then `core_sleep_i`=1 -> `wu_wfe_o`=1 within 2 cycles (no lost wake).
- `clr_valid_i`=1 with `clr_mask_i`=2'b01 in the same cycle as `evt_i`=2'b01 -> `pending[0]` stays 1.
  - The same clear on a later cycle -> `pending[0]`=0 and `irq_o` drops the following cycle.
- Clear request issued during WAKE -> `clr_ready_o`=0, request held, accepted on the first cycle after WAKE.
- `evt_i` held nonzero for 2^CNT_W+5 cycles (CNT_W=4) -> `evt_cnt_o` stops at 4'hF.
- With TILE_EVT_BUSY_WAKE_EN: `busy_i` 1->0 while sleeping, `evt_mask_i`=2'b10 -> `pending_o`=2'b10 and `wu_wfe_o` pulses.
- Assert `rstn_i`=0 mid-WAKE -> all outputs 0 immediately.
